dna_seq_gen: RTL and testbench

DNA_SEQ_GEN -- requirements
Module: dna_seq_gen

---
 rtl/dna_seq_gen.sv | 149 ++++++++++++++
 tb/tb_dna_seq_gen.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dna_seq_gen.sv
// Streams packed 2-bit DNA bases out as ASCII characters, one per cycle,
// fed by a two-word input FIFO so consecutive words play out without a gap.
module dna_seq_gen (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] word_in,
  input  logic        word_valid,
  output logic        word_ready,
  input  logic        hold,
  output logic [7:0]  out,
  output logic        out_valid,
  output logic [7:0]  sent_cnt
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t      state_r;
  state_t      state_next_s;
  logic [31:0] fifo_mem_r [2];
  logic        rd_ptr_r;
  logic        wr_ptr_r;
  logic [1:0]  count_r;
  logic [31:0] shift_r;
  logic [3:0]  base_idx_r;
  logic [7:0]  sent_cnt_r;
  logic        push_s;
  logic        pop_s;
  logic        advance_s;
  logic [1:0]  cur_code_s;

  function automatic logic [7:0] base_ascii(input logic [1:0] code);
    logic [7:0] ch;
    case (code)
      2'b00:   ch = 8'h41;
      2'b01:   ch = 8'h54;
      2'b10:   ch = 8'h47;
      2'b11:   ch = 8'h43;
      default: ch = 8'h00;
    endcase
    return ch;
  endfunction

  // Ready depends only on the registered occupancy, never on a same-cycle pop.
  assign word_ready = (count_r < 2'd2);
  assign push_s     = word_valid & word_ready;
  assign out_valid  = (state_r == SEND);
  assign sent_cnt   = sent_cnt_r;
  assign cur_code_s = shift_r[{base_idx_r, 1'b0} +: 2];

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic with pop and advance decisions.
  always_comb begin
    state_next_s = state_r;
    pop_s        = 1'b0;
    advance_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (count_r != 2'd0) begin
          pop_s        = 1'b1;
          state_next_s = SEND;
        end else begin
          state_next_s = IDLE;
        end
      end
      SEND: begin
        if (!hold) begin
          advance_s = 1'b1;
          if (base_idx_r == 4'd15) begin
            if (count_r != 2'd0) begin
              pop_s        = 1'b1;
              state_next_s = SEND;
            end else begin
              state_next_s = IDLE;
            end
          end else begin
            state_next_s = SEND;
          end
        end else begin
          state_next_s = SEND;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // FIFO storage, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      fifo_mem_r[0] <= 32'h0000_0000;
      fifo_mem_r[1] <= 32'h0000_0000;
      rd_ptr_r      <= 1'b0;
      wr_ptr_r      <= 1'b0;
      count_r       <= 2'd0;
    end else begin
      if (push_s) begin
        fifo_mem_r[wr_ptr_r] <= word_in;
        wr_ptr_r             <= ~wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      count_r <= count_r + {1'b0, push_s} - {1'b0, pop_s};
    end
  end

  // Shift register, base index and emitted-base counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      shift_r    <= 32'h0000_0000;
      base_idx_r <= 4'd0;
      sent_cnt_r <= 8'd0;
    end else begin
      if (pop_s) begin
        shift_r    <= fifo_mem_r[rd_ptr_r];
        base_idx_r <= 4'd0;
      end else if (advance_s) begin
        // Parking the index at 0 on the way back to IDLE keeps it tidy.
        base_idx_r <= (base_idx_r == 4'd15) ? 4'd0 : base_idx_r + 4'd1;
      end
      if (advance_s) begin
        sent_cnt_r <= sent_cnt_r + 8'd1;
      end
    end
  end

  // Character decode of the current base.
  always_comb begin
    out = 8'h00;
    if (state_r == SEND) begin
      out = base_ascii(cur_code_s);
    end else begin
      out = 8'h00;
    end
  end

endmodule

// File: tb/tb_dna_seq_gen.sv
// Scoreboard bench for dna_seq_gen: expected characters are queued when a
// word is accepted and popped as the design emits bases.
module tb_dna_seq_gen;

  logic        clk;
  logic        reset;
  logic [31:0] word_in;
  logic        word_valid;
  logic        word_ready;
  logic        hold;
  logic [7:0]  out;
  logic        out_valid;
  logic [7:0]  sent_cnt;

  int          checks;
  int          errors;
  logic [7:0]  exp_q [$];
  logic [31:0] stim_q [$];
  logic [7:0]  exp_cnt;

  dna_seq_gen dut (
    .clk        (clk),
    .reset      (reset),
    .word_in    (word_in),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .hold       (hold),
    .out        (out),
    .out_valid  (out_valid),
    .sent_cnt   (sent_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] exp_char(input logic [1:0] code);
    case (code)
      2'b00:   return 8'h41;
      2'b01:   return 8'h54;
      2'b10:   return 8'h47;
      default: return 8'h43;
    endcase
  endfunction

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push_expected(input logic [31:0] w);
    for (int k = 0; k < 16; k++) exp_q.push_back(exp_char(w[2*k +: 2]));
  endtask

  task automatic apply_reset();
    reset = 1'b1; word_valid = 1'b0; hold = 1'b0; word_in = 32'h0;
    cycle();
    cycle();
    reset = 1'b0;
    exp_q.delete();
    exp_cnt = 8'd0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (word_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", word_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    checks++; if (out !== 8'h00) begin errors++; $display("FAIL reset_out: got %h want 00", out); end
    checks++; if (sent_cnt !== 8'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", sent_cnt); end
  endtask

  task automatic test_single();
    logic [7:0] e;
    apply_reset();
    word_in = 32'h2E44_2E44; word_valid = 1'b1;
    push_expected(word_in);
    cycle();
    word_valid = 1'b0;
    checks++; if (out_valid !== 1'b0 || out !== 8'h00) begin
      errors++; $display("FAIL single_latency: valid=%b out=%h want 0/00", out_valid, out);
    end
    cycle();
    for (int i = 0; i < 16; i++) begin
      e = exp_q.pop_front();
      checks++; if (out_valid !== 1'b1 || out !== e) begin
        errors++; $display("FAIL single_base%0d: valid=%b out=%h want 1/%h", i, out_valid, out, e);
      end
      checks++; if (sent_cnt !== 8'(i)) begin
        errors++; $display("FAIL single_cnt%0d: got %0d want %0d", i, sent_cnt, i);
      end
      cycle();
    end
    checks++; if (out_valid !== 1'b0 || out !== 8'h00) begin
      errors++; $display("FAIL single_end: valid=%b out=%h want 0/00", out_valid, out);
    end
    checks++; if (sent_cnt !== 8'd16) begin errors++; $display("FAIL single_total: got %0d want 16", sent_cnt); end
  endtask

  // Offers every word in stim_q continuously and checks the emitted stream.
  task automatic test_stream(input string name, input bit expect_full);
    int wi = 0;
    int emitted = 0;
    int cyc = 0;
    bit started = 1'b0;
    bit saw_full = 1'b0;
    logic [7:0] e;
    while ((wi < stim_q.size() || exp_q.size() != 0 || out_valid) && cyc < 2000) begin
      if (out_valid) begin
        started = 1'b1;
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL %s_extra: out=%h with nothing expected", name, out);
        end else begin
          e = exp_q.pop_front();
          if (out !== e) begin errors++; $display("FAIL %s_base%0d: got %h want %h", name, emitted, out, e); end
        end
        checks++; if (sent_cnt !== exp_cnt) begin
          errors++; $display("FAIL %s_cnt%0d: got %0d want %0d", name, emitted, sent_cnt, exp_cnt);
        end
        exp_cnt++;
        emitted++;
      end else begin
        checks++; if (out !== 8'h00) begin errors++; $display("FAIL %s_idle_out: got %h want 00", name, out); end
        checks++; if (started && exp_q.size() != 0) begin
          errors++; $display("FAIL %s_gap: valid=0 with %0d bases pending", name, exp_q.size());
        end
      end
      if (!word_ready) saw_full = 1'b1;
      if (wi < stim_q.size()) begin
        word_valid = 1'b1;
        word_in    = stim_q[wi];
        if (word_ready) begin
          push_expected(stim_q[wi]);
          wi++;
        end
      end else begin
        word_valid = 1'b0;
      end
      cycle();
      cyc++;
    end
    word_valid = 1'b0;
    checks++; if (cyc >= 2000) begin errors++; $display("FAIL %s_timeout: cycles %0d limit 2000", name, cyc); end
    checks++; if (emitted != 16 * stim_q.size()) begin
      errors++; $display("FAIL %s_count: got %0d want %0d", name, emitted, 16 * stim_q.size());
    end
    if (expect_full) begin
      checks++; if (!saw_full) begin errors++; $display("FAIL %s_ready_drop: got never-low want low when full", name); end
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    stim_q.delete();
    stim_q.push_back(32'h0000_0000);
    stim_q.push_back(32'hFFFF_FFFF);
    test_stream("b2b", 1'b0);
    checks++; if (sent_cnt !== 8'd32) begin errors++; $display("FAIL b2b_total: got %0d want 32", sent_cnt); end
  endtask

  task automatic test_three_words();
    apply_reset();
    stim_q.delete();
    stim_q.push_back(32'h2E44_2E44);
    stim_q.push_back(32'h1234_5678);
    stim_q.push_back(32'hDEAD_BEEF);
    test_stream("three", 1'b1);
    checks++; if (sent_cnt !== 8'd48) begin errors++; $display("FAIL three_total: got %0d want 48", sent_cnt); end
  endtask

  task automatic test_hold();
    int v = 0;
    apply_reset();
    word_in = 32'h5555_5555; word_valid = 1'b1;
    cycle();
    word_valid = 1'b0;
    cycle();
    for (int c = 0; c < 40; c++) begin
      if (out_valid) begin
        checks++; if (out !== 8'h54) begin errors++; $display("FAIL hold_out%0d: got %h want 54", v, out); end
        checks++; if (sent_cnt !== exp_cnt) begin
          errors++; $display("FAIL hold_cnt%0d: got %0d want %0d", v, sent_cnt, exp_cnt);
        end
        hold = (v >= 5 && v <= 7);
        if (!hold) exp_cnt++;
        v++;
      end else begin
        hold = 1'b0;
      end
      cycle();
    end
    hold = 1'b0;
    checks++; if (v != 19) begin errors++; $display("FAIL hold_valid_cycles: got %0d want 19", v); end
    checks++; if (sent_cnt !== 8'd16) begin errors++; $display("FAIL hold_total: got %0d want 16", sent_cnt); end
  endtask

  task automatic test_reset_mid();
    int stray = 0;
    apply_reset();
    word_in = 32'h2E44_2E44; word_valid = 1'b1;
    cycle();
    word_valid = 1'b0;
    cycle();
    word_in = 32'hFFFF_FFFF; word_valid = 1'b1;
    cycle();
    word_valid = 1'b0;
    for (int i = 0; i < 6; i++) cycle();
    checks++; if (out !== 8'h41 || sent_cnt !== 8'd7) begin
      errors++; $display("FAIL mid_pre: out=%h cnt=%0d want 41/7", out, sent_cnt);
    end
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    checks++; if (out_valid !== 1'b0 || out !== 8'h00) begin
      errors++; $display("FAIL mid_out: valid=%b out=%h want 0/00", out_valid, out);
    end
    checks++; if (sent_cnt !== 8'd0) begin errors++; $display("FAIL mid_cnt: got %0d want 0", sent_cnt); end
    checks++; if (word_ready !== 1'b1) begin errors++; $display("FAIL mid_ready: got %b want 1", word_ready); end
    for (int i = 0; i < 20; i++) begin
      if (out_valid !== 1'b0) stray++;
      cycle();
    end
    checks++; if (stray != 0) begin errors++; $display("FAIL mid_lost: got %0d valid cycles want 0", stray); end
  endtask

  task automatic test_wrap();
    apply_reset();
    stim_q.delete();
    for (int i = 0; i < 17; i++) stim_q.push_back($urandom);
    test_stream("wrap", 1'b1);
    checks++; if (sent_cnt !== 8'd16) begin errors++; $display("FAIL wrap_total: got %0d want 16", sent_cnt); end
  endtask

  initial begin
    checks = 0; errors = 0; exp_cnt = 8'd0;
    reset = 1'b1; word_valid = 1'b0; hold = 1'b0; word_in = 32'h0;
    @(negedge clk);
    test_reset();
    test_single();
    test_back_to_back();
    test_three_words();
    test_hold();
    test_reset_mid();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
